// File: rtl/frame_builder.sv
// Purpose: builds framed word stream HEADER, CTRL, payload[frame_len], CRC16 from a payload valid/ready input.
// Latency: HEADER appears 1 cycle after an accepted frame_start; each payload word appears 1 cycle after its handshake.
// Backpressure: pld_ready is offered only while payload words are still owed; stalls emit vld=0 bubbles on data_out.
//
// Ports:
//   clk_in, rst_n            : clock (rising edge) and asynchronous active-low reset
//   frame_start/_ch/_len     : frame request, channel mask and payload count (1..8), sampled while busy=0
//   pld_data/_valid/_ready   : payload word input handshake
//   data_out, data_out_vld   : registered frame word stream
//   busy, frame_done, len_err: status; frame_done marks the CRC word, len_err flags a rejected request
//   crc_err_inj              : only with macro FRAME_BUILDER_CRC_INJ_EN; inverts the emitted CRC of that frame
module frame_builder #(
  parameter logic [15:0] HEADER   = 16'hE0E0,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [7:0]  frame_ch,
  input  logic [3:0]  frame_len,
  input  logic [15:0] pld_data,
  input  logic        pld_valid,
`ifdef FRAME_BUILDER_CRC_INJ_EN
  input  logic        crc_err_inj,
`endif
  output logic        pld_ready,
  output logic [15:0] data_out,
  output logic        data_out_vld,
  output logic        busy,
  output logic        frame_done,
  output logic        len_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CTRL,
    S_PLD,
    S_CRC
  } state_t;

  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] len;
  } frame_cfg_t;

  state_t     state_q;
  frame_cfg_t cfg_q;
  logic [3:0] cnt_q;      // payload handshakes completed in this frame
  logic [15:0] crc_q;
  logic [15:0] ctrl_word;
  logic [15:0] crc_word;
  logic        len_ok;

`ifdef FRAME_BUILDER_CRC_INJ_EN
  logic inj_q;
`endif

  // CRC-16/CCITT, MSB first, one full 16-bit word per call.
  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic [15:0] s;
    logic        fb;
    r = c;
    s = d;
    for (int i = 0; i < 16; i++) begin
      fb = r[15] ^ s[15];
      r  = {r[14:0], 1'b0};
      s  = {s[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  assign ctrl_word = {cfg_q.ch, 4'h0, cfg_q.len};
  assign len_ok    = (frame_len != 4'd0) && (frame_len <= 4'd8);

  always_comb begin
    crc_word = crc_q;
`ifdef FRAME_BUILDER_CRC_INJ_EN
    if (inj_q) crc_word = ~crc_q;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cfg_q        <= '0;
      cnt_q        <= '0;
      crc_q        <= CRC_INIT;
      pld_ready    <= 1'b0;
      data_out     <= 16'h0000;
      data_out_vld <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      len_err      <= 1'b0;
`ifdef FRAME_BUILDER_CRC_INJ_EN
      inj_q        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      case (state_q)
        // IDLE and the CRC-word cycle both have busy=0, so either may
        // accept the next request; this is what gives back-to-back frames.
        S_IDLE, S_CRC: begin
          state_q      <= S_IDLE;
          data_out     <= 16'h0000;
          data_out_vld <= 1'b0;
          busy         <= 1'b0;
          pld_ready    <= 1'b0;
          if (frame_start) begin
            if (len_ok) begin
              state_q      <= S_HDR;
              cfg_q.ch     <= frame_ch;
              cfg_q.len    <= frame_len;
              cnt_q        <= '0;
              crc_q        <= CRC_INIT;
              data_out     <= HEADER;
              data_out_vld <= 1'b1;
              busy         <= 1'b1;
`ifdef FRAME_BUILDER_CRC_INJ_EN
              inj_q        <= crc_err_inj;
`endif
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        S_HDR: begin
          state_q      <= S_CTRL;
          data_out     <= ctrl_word;
          data_out_vld <= 1'b1;
          crc_q        <= crc16_word(crc_q, ctrl_word);
        end
        // Nothing can be accepted while CTRL is on the output, so the
        // first PLD cycle always shows a bubble.
        S_CTRL: begin
          state_q      <= S_PLD;
          data_out     <= 16'h0000;
          data_out_vld <= 1'b0;
          pld_ready    <= 1'b1;
        end
        S_PLD: begin
          if (pld_ready && pld_valid) begin
            data_out     <= pld_data;
            data_out_vld <= 1'b1;
            crc_q        <= crc16_word(crc_q, pld_data);
            cnt_q        <= cnt_q + 4'd1;
            if (cnt_q + 4'd1 == cfg_q.len) pld_ready <= 1'b0;
          end else if (!pld_ready) begin
            // All payload taken and the last word is on the output now.
            state_q      <= S_CRC;
            data_out     <= crc_word;
            data_out_vld <= 1'b1;
            frame_done   <= 1'b1;
            busy         <= 1'b0;
          end else begin
            data_out     <= 16'h0000;
            data_out_vld <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          data_out     <= 16'h0000;
          data_out_vld <= 1'b0;
          busy         <= 1'b0;
          pld_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
module tb_frame_builder;

  localparam logic [15:0] HDR = 16'hE0E0;

  typedef struct packed {
    logic [15:0] dat;
    logic        done;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [7:0]  frame_ch;
  logic [3:0]  frame_len;
  logic [15:0] pld_data;
  logic        pld_valid;
  logic        pld_ready;
  logic [15:0] data_out;
  logic        data_out_vld;
  logic        busy;
  logic        frame_done;
  logic        len_err;
`ifdef FRAME_BUILDER_CRC_INJ_EN
  logic        crc_err_inj;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  int   len_err_cnt = 0;
  int   bubble_cnt  = 0;
  int   b2b_left    = 0;
  int   done_base   = 0;
  logic prev_done   = 1'b0;

  exp_t        sb[$];
  logic [15:0] pay [8];

  frame_builder dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .frame_ch     (frame_ch),
    .frame_len    (frame_len),
    .pld_data     (pld_data),
    .pld_valid    (pld_valid),
`ifdef FRAME_BUILDER_CRC_INJ_EN
    .crc_err_inj  (crc_err_inj),
`endif
    .pld_ready    (pld_ready),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .busy         (busy),
    .frame_done   (frame_done),
    .len_err      (len_err)
  );

  always #5 clk_in = ~clk_in;

  // Byte-at-a-time CRC-16/CCITT reference.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic [7:0]  b;
    r = c;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? w[15:8] : w[7:0];
      r = r ^ {b, 8'h00};
      for (int j = 0; j < 8; j++) begin
        if (r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
        else       r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic done);
    exp_t e;
    e.dat  = d;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] ch, input logic [3:0] len, input int off, input logic inj);
    logic [15:0] ctrl;
    logic [15:0] crc;
    ctrl = {ch, 4'h0, len};
    crc  = crc_model(16'hFFFF, ctrl);
    push_word(HDR, 1'b0);
    push_word(ctrl, 1'b0);
    for (int i = 0; i < int'(len); i++) begin
      crc = crc_model(crc, pay[off + i]);
      push_word(pay[off + i], 1'b0);
    end
    if (inj) crc = ~crc;
    push_word(crc, 1'b1);
  endtask

  // All stimulus tasks start and end at posedge+2.
  task automatic start_frame(input logic [7:0] ch, input logic [3:0] len);
    frame_start = 1'b1;
    frame_ch    = ch;
    frame_len   = len;
    @(posedge clk_in); #2;
    frame_start = 1'b0;
  endtask

  task automatic feed(input int len, input bit toggle);
    int   idx;
    int   cyc;
    logic hs;
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 200) begin
      pld_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      pld_data  = pay[idx];
      #4;
      hs = pld_valid && pld_ready;
      @(posedge clk_in); #2;
      if (hs) idx++;
      cyc++;
    end
    pld_valid = 1'b0;
    pld_data  = 16'h0000;
    chk("feed_complete", idx, len);
  endtask

  task automatic wait_done(input string name, input int n);
    int c;
    c = 0;
    while (done_cnt < done_base + n && c < 60) begin
      @(posedge clk_in); #2;
      c++;
    end
    chk(name, done_cnt, done_base + n);
    @(posedge clk_in); #2;
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Scoreboard monitor: compares every output cycle against the queue.
  always @(negedge clk_in) begin
    exp_t e;
    vectors++;
    if (data_out_vld) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got %h done=%b, expected no word", data_out, frame_done);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.dat || frame_done !== e.done) begin
          miscompares++;
          $display("FAIL stream_word: got %h done=%b, expected %h done=%b",
                   data_out, frame_done, e.dat, e.done);
        end
      end
    end else if (data_out !== 16'h0000 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_word: got %h done=%b, expected 0000 done=0", data_out, frame_done);
    end
    if (prev_done && b2b_left > 0) begin
      vectors++;
      b2b_left--;
      if (!(data_out_vld === 1'b1 && data_out === HDR)) begin
        miscompares++;
        $display("FAIL b2b_gap: got vld=%b %h after CRC, expected vld=1 %h", data_out_vld, data_out, HDR);
      end
    end
    if (len_err === 1'b1) len_err_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (busy === 1'b1 && data_out_vld === 1'b0) bubble_cnt++;
    prev_done = frame_done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    frame_ch    = 8'h00;
    frame_len   = 4'd0;
    pld_data    = 16'h0000;
    pld_valid   = 1'b0;
`ifdef FRAME_BUILDER_CRC_INJ_EN
    crc_err_inj = 1'b0;
`endif
    repeat (3) @(posedge clk_in);
    #2;
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_vld", data_out_vld, 1'b0);
    chk("rst_pld_ready", pld_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk_in); #2;

    // Single-word frame, payload always valid.
    pay[0] = 16'h1234;
    push_word(16'hE0E0, 1'b0);
    push_word(16'h0101, 1'b0);
    push_word(16'h1234, 1'b0);
    push_word(crc_model(crc_model(16'hFFFF, 16'h0101), 16'h1234), 1'b1);
    done_base  = done_cnt;
    bubble_cnt = 0;
    start_frame(8'h01, 4'd1);
    chk("hdr_busy", busy, 1'b1);
    feed(1, 0);
    wait_done("t1_done", 1);
    chk("t1_bubbles", bubble_cnt, 1);

    // Eight words with valid toggling: stall bubbles must not disturb CRC.
    for (int i = 0; i < 8; i++) pay[i] = 16'(16'h1000 * (i + 1) + 16'h00C3);
    push_frame(8'hFF, 4'd8, 0, 1'b0);
    done_base  = done_cnt;
    bubble_cnt = 0;
    start_frame(8'hFF, 4'd8);
    feed(8, 1);
    wait_done("t2_done", 1);
    chk("t2_bubbles_min", (bubble_cnt >= 8), 1);

    // frame_start held high: three back-to-back frames of two words.
    for (int i = 0; i < 6; i++) pay[i] = 16'(16'h0100 + i);
    push_frame(8'h03, 4'd2, 0, 1'b0);
    push_frame(8'h03, 4'd2, 2, 1'b0);
    push_frame(8'h03, 4'd2, 4, 1'b0);
    done_base   = done_cnt;
    base        = len_err_cnt;
    b2b_left    = 2;
    frame_start = 1'b1;
    frame_ch    = 8'h03;
    frame_len   = 4'd2;
    @(posedge clk_in); #2;
    feed(6, 0);
    frame_start = 1'b0;
    wait_done("t3_done", 3);
    chk("t3_b2b_seen", b2b_left, 0);
    chk("t3_no_len_err", len_err_cnt, base);

    // Illegal lengths 0 and 9.
    base = len_err_cnt;
    start_frame(8'h55, 4'd0);
    chk("len0_err", len_err, 1'b1);
    chk("len0_busy", busy, 1'b0);
    chk("len0_vld", data_out_vld, 1'b0);
    @(posedge clk_in); #2;
    chk("len0_err_pulse", len_err, 1'b0);
    start_frame(8'h55, 4'd9);
    chk("len9_err", len_err, 1'b1);
    chk("len9_busy", busy, 1'b0);
    @(posedge clk_in); #2;
    chk("len9_err_pulse", len_err, 1'b0);
    chk("len_err_count", len_err_cnt, base + 2);
    chk("len_err_no_words", sb.size(), 0);

    // Reset while the third payload word of an 8-word frame is shown.
    for (int i = 0; i < 8; i++) pay[i] = 16'(16'hC000 + i);
    push_word(16'hE0E0, 1'b0);
    push_word(16'h8008, 1'b0);
    push_word(16'hC000, 1'b0);
    push_word(16'hC001, 1'b0);
    done_base = done_cnt;
    start_frame(8'h80, 4'd8);
    feed(3, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_data_out", data_out, 16'h0000);
    chk("arst_vld", data_out_vld, 1'b0);
    chk("arst_pld_ready", pld_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", frame_done, 1'b0);
    repeat (2) @(posedge clk_in);
    #2 rst_n = 1'b1;
    chk("arst_no_done", done_cnt, done_base);
    chk("arst_sb_empty", sb.size(), 0);
    @(posedge clk_in); #2;
    pay[0] = 16'hBEEF;
    push_frame(8'h02, 4'd1, 0, 1'b0);
    done_base = done_cnt;
    start_frame(8'h02, 4'd1);
    feed(1, 0);
    wait_done("t5_after_reset", 1);

`ifdef FRAME_BUILDER_CRC_INJ_EN
    // Corrupted CRC, then a clean frame.
    pay[0] = 16'h0F0F;
    pay[1] = 16'hF0F0;
    pay[2] = 16'h3C3C;
    push_frame(8'h10, 4'd3, 0, 1'b1);
    done_base   = done_cnt;
    crc_err_inj = 1'b1;
    start_frame(8'h10, 4'd3);
    crc_err_inj = 1'b0;
    feed(3, 0);
    wait_done("t6_inj", 1);
    push_frame(8'h10, 4'd3, 0, 1'b0);
    done_base = done_cnt;
    start_frame(8'h10, 4'd3);
    feed(3, 0);
    wait_done("t6_clean", 1);
`endif

    repeat (3) @(posedge clk_in);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_builder.md
FRAME_BUILDER -- requirements
Module: frame_builder

Interface
REQ-001 The module SHALL have parameter HEADER, default 16'hE0E0, the frame sync word emitted first in every frame.
REQ-002 The module SHALL have parameter CRC_INIT, default 16'hFFFF, the CRC16 seed applied at each frame start.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset; no other clock exists in the block.
REQ-004 The module SHALL have port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port frame_start  input  1  request a new frame; sampled only while busy=0.
REQ-007 The module SHALL have port frame_ch  input  8  channel-valid mask; bit k set means channel k+1 carries data.
REQ-008 The module SHALL have port frame_len  input  4  payload word count; legal range 1..8.
REQ-009 The module SHALL have port pld_data  input  16  payload word.
REQ-010 The module SHALL have port pld_valid  input  1  pld_data is valid.
REQ-011 The module SHALL have port pld_ready  output  1  builder accepts pld_data this cycle.
REQ-012 The module SHALL have port data_out  output  16  registered frame word stream.
REQ-013 The module SHALL have port data_out_vld  output  1  data_out carries a frame word.
REQ-014 The module SHALL have port busy  output  1  frame in progress; frame_start ignored.
REQ-015 The module SHALL have port frame_done  output  1  one-cycle pulse coincident with the CRC word.
REQ-016 The module SHALL have port len_err  output  1  one-cycle pulse on a rejected frame_start.

Function
REQ-017 Frame word order SHALL be: HEADER, CTRL = {frame_ch[7:0], 4'h0, frame_len[3:0]}, frame_len payload words, CRC word.
REQ-018 CRC SHALL be CRC-16/CCITT (poly 0x1021, MSB-first, no reflection, no final XOR), seeded with CRC_INIT, computed over CTRL and all payload words, one 16-bit word per cycle, excluding HEADER.
REQ-019 FSM states SHALL be IDLE, HDR, CTRL, PLD, CRC; IDLE->HDR on accepted start, HDR->CTRL->PLD unconditionally, PLD->CRC after the frame_len-th handshake, CRC->HDR if a new start is accepted in that cycle, else CRC->IDLE.
REQ-020 frame_start SHALL be accepted at an edge where busy=0 and 1<=frame_len<=8; frame_ch and frame_len SHALL be latched at that edge.
REQ-021 HEADER SHALL appear on data_out with data_out_vld=1 in the cycle after acceptance; CTRL follows in the next cycle.
REQ-022 pld_ready SHALL be 1 only in state PLD; a word transfers when pld_valid&pld_ready at a rising edge and appears on data_out the following cycle.
REQ-023 In PLD, a cycle without handshake SHALL produce data_out_vld=0 and data_out=16'h0000 in the following cycle (stall bubble); bubbles do not update the CRC.
REQ-024 busy SHALL be 1 from the cycle after acceptance through the last payload cycle and 0 in the CRC-word cycle, allowing back-to-back frames with zero idle words.
REQ-025 frame_start with frame_len=0 or >8 while busy=0 SHALL be dropped, produce no frame words, and pulse len_err for one cycle the following cycle.
REQ-026 frame_start while busy=1 SHALL be ignored silently (no len_err).
REQ-027 In IDLE, data_out SHALL be 16'h0000 and data_out_vld=0.

Reset
REQ-028 On rst_n=0, all outputs SHALL go to 0 immediately (data_out=16'h0000, data_out_vld, pld_ready, busy, frame_done, len_err), state to IDLE, CRC to CRC_INIT.
REQ-029 Reset mid-frame SHALL abandon the frame with no frame_done; the first frame after release restarts from HEADER.

Configuration
REQ-030 With macro FRAME_BUILDER_CRC_INJ_EN defined, input crc_err_inj (1 bit) SHALL exist, be latched at frame acceptance, and when set the emitted CRC word SHALL be the bitwise inverse of the computed CRC.
REQ-031 Without FRAME_BUILDER_CRC_INJ_EN, port crc_err_inj SHALL be absent and the CRC is always emitted uncorrupted.

Verification
REQ-032 Reset release, then frame_start with frame_ch=8'h01, frame_len=1, and pld_valid held 1 with pld_data=16'h1234 -> data_out sequence E0E0, 0101, 1234, CRC matching the model; frame_done pulses with the CRC word.
REQ-033 frame_len=8, frame_ch=8'hFF, pld_valid toggled 1/0 every cycle -> 8 payload words interleaved with vld=0 bubbles of data 0000; CRC unaffected by bubbles.
REQ-034 frame_start held high continuously with frame_len=2 -> consecutive frames with HEADER directly following the CRC word and no idle cycle.
REQ-035 frame_start with frame_len=0, then frame_len=9 -> len_err pulses twice, data_out_vld stays 0, busy stays 0.
REQ-036 rst_n asserted during the third payload word of a frame_len=8 frame -> outputs 0 asynchronously, no frame_done; the next frame begins with E0E0.
REQ-037 With FRAME_BUILDER_CRC_INJ_EN defined and crc_err_inj=1 at start -> CRC word equals ~model CRC; the following frame with crc_err_inj=0 carries the correct CRC.
